// File: rtl/pp_pipeline_accel_mul_pipe_pkg.sv
// Shared helpers for the pipelined multiplier: stage-count check, product width
// and saturation bounds. Bounds are held in a wide signed type so any OUT_W compares cleanly.
package pp_pipeline_accel_mul_pkg;

  localparam int BOUND_W = 128;
  typedef logic signed [BOUND_W-1:0] bound_t;

  function automatic bit stage_ok(int n);
    return (n >= 1) && (n <= 6);
  endfunction

  function automatic int prod_width(int a_w, int b_w);
    return a_w + b_w;
  endfunction

  function automatic bound_t sat_max(int out_w, bit sgn);
    bound_t one;
    one = bound_t'(1);
    return sgn ? (one <<< (out_w - 1)) - one : (one <<< out_w) - one;
  endfunction

  function automatic bound_t sat_min(int out_w, bit sgn);
    bound_t one;
    one = bound_t'(1);
    return sgn ? -(one <<< (out_w - 1)) : '0;
  endfunction

endpackage

// File: rtl/pp_pipeline_accel_mul_pipe_if.sv
// Operand/result handshake bundle for pp_pipeline_accel_mul_pipe.
interface pp_pipeline_accel_mul_pipe_if #(
  parameter int A_W   = 11,
  parameter int B_W   = 11,
  parameter int OUT_W = 22
);
  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] p;
  logic             sat;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, sat
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, sat
  );
endinterface

// File: rtl/pp_pipeline_accel_mul_pipe_rndsat.sv
// Combinational round (PP_MUL_ROUND_EN: half-up), shift and saturate of the full product.
// Without PP_MUL_ROUND_EN the shift simply truncates the low SHIFT bits.
module pp_pipeline_accel_mul_rndsat
  import pp_pipeline_accel_mul_pkg::*;
#(
  parameter int PW         = 22,
  parameter int OUT_W      = 22,
  parameter int SHIFT      = 0,
  parameter int RES_SIGNED = 0
) (
  input  logic [PW-1:0]    prod,
  output logic [OUT_W-1:0] p,
  output logic             sat
);
  // Two guard bits keep the rounding add from wrapping in either signedness.
  localparam int XW = PW + 2;
  localparam bound_t MAXV = sat_max(OUT_W, RES_SIGNED != 0);
  localparam bound_t MINV = sat_min(OUT_W, RES_SIGNED != 0);
`ifdef PP_MUL_ROUND_EN
  localparam logic signed [XW-1:0] HALF =
    (SHIFT > 0) ? (XW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`endif

  logic signed [XW-1:0] ext;
  logic signed [XW-1:0] shf;
  bound_t               wide;

  always_comb begin
    ext = {{2{(RES_SIGNED != 0) && prod[PW-1]}}, prod};
`ifdef PP_MUL_ROUND_EN
    ext = ext + HALF;
`endif
    shf  = ext >>> SHIFT;
    wide = bound_t'(shf);
    p    = wide[OUT_W-1:0];
    sat  = 1'b0;
    if (wide > MAXV) begin
      p   = MAXV[OUT_W-1:0];
      sat = 1'b1;
    end else if (wide < MINV) begin
      p   = MINV[OUT_W-1:0];
      sat = 1'b1;
    end
  end
endmodule

// File: rtl/pp_pipeline_accel_mul_pipe.sv
// NUM_STAGE-deep multiply/round/saturate pipeline with a global stall on out_ready.
// Optional half-up rounding is enabled by defining PP_MUL_ROUND_EN.
module pp_pipeline_accel_mul_pipe
  import pp_pipeline_accel_mul_pkg::*;
#(
  parameter int A_W       = 11,
  parameter int B_W       = 11,
  parameter int OUT_W     = 22,
  parameter int NUM_STAGE = 3,
  parameter int A_SIGNED  = 0,
  parameter int B_SIGNED  = 0,
  parameter int SHIFT     = 0
) (
  input logic clk,
  input logic reset,
  pp_pipeline_accel_mul_pipe_if.slave bus
);
  localparam int PW         = prod_width(A_W, B_W);
  localparam int RES_SIGNED = ((A_SIGNED != 0) || (B_SIGNED != 0)) ? 1 : 0;

  if (!stage_ok(NUM_STAGE)) begin : g_bad_stage
    $error("NUM_STAGE must be within 1..6");
  end

  logic                 advance;
  logic [NUM_STAGE-1:0] vld;
  logic [A_W-1:0]       op_a;
  logic [B_W-1:0]       op_b;
  logic signed [PW-1:0] a_x;
  logic signed [PW-1:0] b_x;
  logic [PW-1:0]        prod_c;
  logic [PW-1:0]        prod_last;
  logic [OUT_W-1:0]     rs_p;
  logic                 rs_sat;
  logic [OUT_W-1:0]     p_q;
  logic                 sat_q;

  assign advance       = !vld[NUM_STAGE-1] || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = vld[NUM_STAGE-1];
  assign bus.p         = p_q;
  assign bus.sat       = sat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
    end else if (advance) begin
      vld[0] <= bus.in_valid;
      for (int unsigned i = 1; i < NUM_STAGE; i++) vld[i] <= vld[i-1];
    end
  end

  // With a single stage the multiplier sits directly between the ports and the output register.
  if (NUM_STAGE >= 2) begin : g_in_reg
    logic [A_W-1:0] a_q;
    logic [B_W-1:0] b_q;
    always_ff @(posedge clk) begin
      if (advance) begin
        a_q <= bus.a;
        b_q <= bus.b;
      end
    end
    assign op_a = a_q;
    assign op_b = b_q;
  end else begin : g_in_comb
    assign op_a = bus.a;
    assign op_b = bus.b;
  end

  assign a_x    = {{B_W{(A_SIGNED != 0) && op_a[A_W-1]}}, op_a};
  assign b_x    = {{A_W{(B_SIGNED != 0) && op_b[B_W-1]}}, op_b};
  assign prod_c = a_x * b_x;

  if (NUM_STAGE >= 3) begin : g_prod_regs
    logic [PW-1:0] prod_q [NUM_STAGE-2];
    always_ff @(posedge clk) begin
      if (advance) begin
        prod_q[0] <= prod_c;
        for (int unsigned i = 1; i < NUM_STAGE - 2; i++) prod_q[i] <= prod_q[i-1];
      end
    end
    assign prod_last = prod_q[NUM_STAGE-3];
  end else begin : g_prod_comb
    assign prod_last = prod_c;
  end

  pp_pipeline_accel_mul_rndsat #(
    .PW         (PW),
    .OUT_W      (OUT_W),
    .SHIFT      (SHIFT),
    .RES_SIGNED (RES_SIGNED)
  ) u_rndsat (
    .prod (prod_last),
    .p    (rs_p),
    .sat  (rs_sat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q   <= '0;
      sat_q <= 1'b0;
    end else if (advance) begin
      p_q   <= rs_p;
      sat_q <= rs_sat;
    end
  end
endmodule

// File: doc/pp_pipeline_accel_mul_pipe.md
PP_PIPELINE_ACCEL_MUL_PIPE -- requirements
Module: pp_pipeline_accel_mul_pipe

Interface
REQ-001 SHALL have parameter A_W, default 11: width of operand a.
REQ-002 SHALL have parameter B_W, default 11: width of operand b.
REQ-003 SHALL have parameter OUT_W, default 22: width of result p.
REQ-004 SHALL have parameter NUM_STAGE, default 3: input-to-output latency in cycles, legal range 1..6.
REQ-005 SHALL have parameters A_SIGNED and B_SIGNED, default 0: 1 selects two's-complement for that operand.
REQ-006 SHALL have parameter SHIFT, default 0: right shift applied to the full product, legal range 0..A_W+B_W-1.
REQ-007 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port in_valid, input, 1 bit: the operands are valid.
REQ-010 SHALL have port in_ready, output, 1 bit: the operands are accepted this cycle.
REQ-011 SHALL have port a, input, A_W bits, and port b, input, B_W bits: the operands.
REQ-012 SHALL have port out_valid, output, 1 bit: p is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts p.
REQ-014 SHALL have port p, output, OUT_W bits: the result; signed if either operand is signed, otherwise unsigned.
REQ-015 SHALL have port sat, output, 1 bit: the result in p was clamped.

Function
REQ-016 SHALL form the full product at A_W+B_W bits, sign-extending each operand only when its *_SIGNED parameter is 1.
REQ-017 SHALL shift the product right by SHIFT: arithmetic shift when the result is signed, logical otherwise.
REQ-018 SHALL saturate the shifted value to the OUT_W range (signed or unsigned), asserting sat with the same beat on overflow.
REQ-019 SHALL compute advance = !out_valid || out_ready, drive in_ready = advance, and advance all stages together only when advance is 1 (global stall).
REQ-020 SHALL accept a beat on in_valid && in_ready and present it on p/out_valid exactly NUM_STAGE advancing cycles later.
REQ-021 SHALL carry a valid bit per stage, so bubbles propagate and never produce out_valid.
REQ-022 SHALL hold p, sat and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL sustain one result per cycle when out_ready is held at 1.
REQ-024 SHALL keep in_ready high while the pipeline is empty, regardless of out_ready.

Reset
REQ-025 SHALL clear every stage valid bit on reset and drive out_valid=0, p=0, sat=0 in the cycle after reset is sampled.
REQ-026 SHALL discard any in-flight beats when reset is asserted mid-operation, and drive in_ready=1 after reset is released.
REQ-027 SHALL leave operand data registers unreset; only the valid bits, p and sat are reset.

Configuration
REQ-028 SHALL round half-up when PP_MUL_ROUND_EN is defined: add 2^(SHIFT-1) before the shift when SHIFT>0, with saturation applied afterwards.
REQ-029 SHALL truncate without PP_MUL_ROUND_EN; the shift discards the low SHIFT bits.

Structure
REQ-030 SHALL place in package pp_pipeline_accel_mul_pkg the functions for the NUM_STAGE legal range check, the product width and the OUT_W min/max saturation bounds.
REQ-031 SHALL implement round/shift/saturate in one combinational sub-module, pp_pipeline_accel_mul_rndsat, placed ahead of the final register stage.
REQ-032 SHALL place the multiply in the first stage after the input register so that it maps onto a DSP48, with the remaining stages used as DSP pipeline registers.

Verification
REQ-033 SHALL cover defaults, a=2047, b=2047, out_ready=1 -> p=4190209, sat=0, out_valid 3 cycles after acceptance.
REQ-034 SHALL cover A_SIGNED=B_SIGNED=1, a=-1024, b=1023 -> p=-1047552, sat=0.
REQ-035 SHALL cover OUT_W=16, SHIFT=4, unsigned, a=b=2047 -> p=65535, sat=1.
REQ-036 SHALL cover SHIFT=2, a=5, b=3 -> p=4 with PP_MUL_ROUND_EN defined and p=3 without it.
REQ-037 SHALL cover back-to-back beats 1..8 with out_ready low for 5 cycles mid-stream -> in_ready=0 and p held during the stall, all 8 products delivered in order with none lost or duplicated.
REQ-038 SHALL cover reset asserted for 1 cycle with 2 beats in flight -> no out_valid from those beats, and a new beat accepted immediately after reset.
